// File: rtl/riscv_uart_loader.sv
// Boot loader: receives a length-prefixed image over 8N1 UART and writes it word by word into RAM, holding the core in reset until done.
// Latency: we rises 1 cycle after the stop-bit sample of each word's 4th byte; done/core_reset release 1 cycle after the last we.
// Backpressure: none; the RAM write port is assumed to accept a write every cycle.
module riscv_uart_loader #(
    parameter int CLK_FREQ    = 27_000_000,
    parameter int BAUD        = 115_200,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        uart_rx,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        core_reset,
    output logic        done,
    output logic        err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(DEPTH_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_LEN_LO, L_LEN_HI, L_DATA, L_LAST, L_DONE, L_ERR} ld_state_t;

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             tick;
    logic             byte_valid;
    logic             frame_err;
    logic [7:0]       byte_data;

    ld_state_t        ld_state, ld_next;
    logic [7:0]       len_lo;
    logic [15:0]      n_words;
    logic [15:0]      wcnt;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
    logic [15:0]      new_len;
    logic             word_wr;

    always_ff @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // START waits half a bit so every later sample lands mid-bit
    assign tick      = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
    assign byte_data = rx_shift;

    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (tick) begin
                    rx_next    = RX_IDLE;
                    byte_valid = rx_sync;
                    frame_err  = !rx_sync;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            bit_idx  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == RX_IDLE || tick) ? '0 : rx_cnt + 1'b1;
            if (rx_state == RX_START)
                bit_idx <= 3'd0;
            if (rx_state == RX_DATA && tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                bit_idx  <= bit_idx + 1'b1;
            end
        end
    end

    assign new_len = {byte_data, len_lo};

    always_comb begin
        ld_next = ld_state;
        word_wr = 1'b0;
        case (ld_state)
            L_LEN_LO: begin
                if (frame_err)       ld_next = L_ERR;
                else if (byte_valid) ld_next = L_LEN_HI;
            end
            L_LEN_HI: begin
                if (frame_err)                           ld_next = L_ERR;
                else if (byte_valid) begin
                    if (new_len == 16'd0)                ld_next = L_DONE;
                    else if ({1'b0, new_len} > MAX_WORDS) ld_next = L_ERR;
                    else                                 ld_next = L_DATA;
                end
            end
            L_DATA: begin
                if (frame_err) ld_next = L_ERR;
                else if (byte_valid && byte_idx == 2'd3) begin
                    word_wr = 1'b1;
                    ld_next = (wcnt + 16'd1 == n_words) ? L_LAST : L_DATA;
                end
            end
            // one extra cycle so core_reset drops only after the last write lands
            L_LAST:  ld_next = L_DONE;
            L_DONE:  ld_next = L_DONE;
            L_ERR:   ld_next = L_ERR;
            default: ld_next = L_LEN_LO;
        endcase
    end

    always_ff @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            ld_state <= L_LEN_LO;
            len_lo   <= 8'd0;
            n_words  <= 16'd0;
            wcnt     <= 16'd0;
            byte_idx <= 2'd0;
            word_buf <= 24'd0;
            we       <= 1'b0;
            waddr    <= 32'd0;
            wdata    <= 32'd0;
        end else begin
            ld_state <= ld_next;
            we       <= word_wr;
            if (ld_state == L_LEN_LO && byte_valid)
                len_lo <= byte_data;
            if (ld_state == L_LEN_HI && byte_valid)
                n_words <= new_len;
            if (ld_state == L_DATA && byte_valid) begin
                byte_idx <= byte_idx + 1'b1;
                if (word_wr) begin
                    wdata <= {byte_data, word_buf};
                    waddr <= {14'd0, wcnt, 2'b00};
                    wcnt  <= wcnt + 16'd1;
                end else begin
                    word_buf <= {byte_data, word_buf[23:8]};
                end
            end
        end
    end

    assign done       = (ld_state == L_DONE);
    assign err        = (ld_state == L_ERR);
    assign core_reset = !done;

endmodule

// File: tb/tb_riscv_uart_loader.sv
// Directed bench for riscv_uart_loader: bit-banged UART frames, a negedge monitor logging writes and done/err edges.
// Byte start at cycle c0 puts the stop-bit sample on edge c0+155 (2-flop sync, half-bit start wait, 16 clk/bit).
module tb_riscv_uart_loader;

    logic        clk = 1'b0;
    logic        x_reset;
    logic        uart_rx;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    riscv_uart_loader #(
        .CLK_FREQ   (160),
        .BAUD       (10),
        .DEPTH_WORDS(4)
    ) dut (
        .clk       (clk),
        .x_reset   (x_reset),
        .uart_rx   (uart_rx),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .core_reset(core_reset),
        .done      (done),
        .err       (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int byte_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          done_rise = -1;
    int          err_rise  = -1;
    bit          err_seen  = 1'b0;
    logic        done_d    = 1'b0;
    logic        err_d     = 1'b0;

    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            wc_q.push_back(cyc);
        end
        if (err) err_seen = 1'b1;
        if (done && !done_d) done_rise = cyc;
        if (err && !err_d) err_rise = cyc;
        done_d = done;
        err_d  = err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_rise = -1;
        err_rise  = -1;
        err_seen  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame      = {stop_bit, b, 1'b0};
        byte_start = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        x_reset = 1'b1;
        repeat (3) @(negedge clk);
        x_reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    32'(we),         32'd0);
        check({tag, "_waddr"}, waddr,           32'd0);
        check({tag, "_wdata"}, wdata,           32'd0);
        check({tag, "_crst"},  32'(core_reset), 32'd1);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_err"},   32'(err),        32'd0);
    endtask

    initial begin
        x_reset = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        x_reset = 1'b0;
        repeat (4) @(negedge clk);

        // two-word load
        clear_mon();
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h6F, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        check("s1_nwe",   32'(wa_q.size()), 32'd2);
        check("s1_wa0",   wa_q.size() > 0 ? wa_q[0] : 32'hDEAD_BEEF, 32'h0);
        check("s1_wd0",   wd_q.size() > 0 ? wd_q[0] : 32'hDEAD_BEEF, 32'h0010_0513);
        check("s1_wa1",   wa_q.size() > 1 ? wa_q[1] : 32'hDEAD_BEEF, 32'h4);
        check("s1_wd1",   wd_q.size() > 1 ? wd_q[1] : 32'hDEAD_BEEF, 32'h0000_006F);
        check("s1_dtime", 32'(done_rise), wc_q.size() > 1 ? 32'(wc_q[1] + 1) : 32'hDEAD_BEEF);
        check("s1_done",  32'(done), 32'd1);
        check("s1_crst",  32'(core_reset), 32'd0);
        check("s1_noerr", 32'(err_seen), 32'd0);
        check("s1_hold",  waddr, 32'h4);

        // traffic after done is ignored
        clear_mon();
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check("s6_nwe",   32'(wa_q.size()), 32'd0);
        check("s6_done",  32'(done), 32'd1);
        check("s6_noerr", 32'(err_seen), 32'd0);
        check("s6_crst",  32'(core_reset), 32'd0);

        // zero length
        do_reset();
        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        check("s2_dtime", 32'(done_rise), 32'(byte_start + 155));
        check("s2_nwe",   32'(wa_q.size()), 32'd0);
        check("s2_crst",  32'(core_reset), 32'd0);
        check("s2_noerr", 32'(err_seen), 32'd0);

        // oversize length
        do_reset();
        clear_mon();
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        check("s3_etime", 32'(err_rise), 32'(byte_start + 155));
        send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        repeat (10) @(negedge clk);
        check("s3_err",  32'(err), 32'd1);
        check("s3_crst", 32'(core_reset), 32'd1);
        check("s3_done", 32'(done), 32'd0);
        check("s3_nwe",  32'(wa_q.size()), 32'd0);

        // framing error mid-word
        do_reset();
        clear_mon();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        repeat (10) @(negedge clk);
        check("s4_etime", 32'(err_rise), 32'(byte_start + 155));
        check("s4_err",   32'(err), 32'd1);
        check("s4_nwe",   32'(wa_q.size()), 32'd0);
        x_reset = 1'b1;
        #1;
        check_reset_vals("s4_rst");
        @(negedge clk);
        x_reset = 1'b0;
        repeat (4) @(negedge clk);

        // glitch, then reset mid-load, then a clean load
        clear_mon();
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("s5_gl_nwe", 32'(wa_q.size()), 32'd0);
        check("s5_gl_err", 32'(err_seen), 32'd0);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        x_reset = 1'b1;
        #1;
        check("s5_rst_we",   32'(we), 32'd0);
        check("s5_rst_crst", 32'(core_reset), 32'd1);
        @(negedge clk);
        x_reset = 1'b0;
        repeat (4) @(negedge clk);
        clear_mon();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h11, 1'b1);
        repeat (20) @(negedge clk);
        check("s5_nwe",   32'(wa_q.size()), 32'd1);
        check("s5_wa0",   wa_q.size() > 0 ? wa_q[0] : 32'hDEAD_BEEF, 32'h0);
        check("s5_wd0",   wd_q.size() > 0 ? wd_q[0] : 32'hDEAD_BEEF, 32'h1122_3344);
        check("s5_dtime", 32'(done_rise), wc_q.size() > 0 ? 32'(wc_q[0] + 1) : 32'hDEAD_BEEF);
        check("s5_done",  32'(done), 32'd1);
        check("s5_noerr", 32'(err_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
